// File: rtl/lamp_pkg.sv
// -----------------------------------------------------------------------------
// lamp_pkg
//   Shared definitions for the multi-way lamp controller front end.
//   - N_SW_DEF   : default number of wall switches (shared with lamp controller)
//   - DB_NUM_DEF : default debounce counter width
//   - DB_MAX_DEF : default debounce terminal count
//   - db_state_e : per-channel debounce FSM state encoding
// -----------------------------------------------------------------------------
package lamp_pkg;

    localparam int              N_SW_DEF   = 3;
    localparam int              DB_NUM_DEF = 20;
    localparam logic [19:0]     DB_MAX_DEF = 20'hF_FFFF;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } db_state_e;

endpackage : lamp_pkg

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   One switch channel: two-flop synchronizer followed by a STABLE/SETTLING
//   debounce FSM. A new level is accepted only after DB_MAX+2 consecutive
//   synchronized samples that differ from the current debounced level.
//
// Ports
//   clk        in   system clock, posedge
//   rst_n      in   asynchronous active-low reset
//   sw_raw     in   raw switch pin, asynchronous to clk
//   sw_stable  out  debounced level (registered)
//   commit     out  combinational: high in the cycle whose closing edge
//                   loads a new value into sw_stable
// -----------------------------------------------------------------------------
module sw_debounce
    import lamp_pkg::*;
#(
    parameter int                 DB_NUM = DB_NUM_DEF,
    parameter logic [DB_NUM-1:0]  DB_MAX = DB_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_stable,
    output logic commit
);

    logic              sync1_q;
    logic              sync2_q;
    db_state_e         state_q,  state_d;
    logic [DB_NUM-1:0] cnt_q,    cnt_d;
    logic              stable_q, stable_d;
    logic              differ;

    assign differ = (sync2_q != stable_q);

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        commit   = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (differ) begin
                    state_d = ST_SETTLING;
                    cnt_d   = '0;
                end
            end
            ST_SETTLING: begin
                if (!differ) begin
                    // Bounce back to the old level: drop the attempt.
                    state_d = ST_STABLE;
                end else if (cnt_q == DB_MAX) begin
                    // Terminal compare comes before the increment, so the
                    // counter can never wrap.
                    stable_d = sync2_q;
                    commit   = 1'b1;
                    state_d  = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign sw_stable = stable_q;

endmodule : sw_debounce

// File: rtl/lamp_switch_conditioner.sv
// -----------------------------------------------------------------------------
// lamp_switch_conditioner
//   Input front end for the multi-way lamp controller. Debounces N_SW raw
//   wall switches and produces a clean single-cycle toggle event for the
//   lamp timer, suppressed until the power-up arming window has elapsed.
//
// Ports
//   clk        in   system clock, posedge
//   rst_n      in   asynchronous active-low reset
//   sw_raw     in   raw switch pins [N_SW], asynchronous to clk
//   sw_stable  out  debounced switch levels [N_SW], registered
//   parity     out  XOR of sw_stable (lamp-request level), registered
//   toggle     out  one-cycle strobe: a debounced level changed while armed
//   changed    out  bits that committed this cycle [N_SW]; zero unless toggle
// -----------------------------------------------------------------------------
module lamp_switch_conditioner
    import lamp_pkg::*;
#(
    parameter int                 N_SW   = N_SW_DEF,
    parameter int                 DB_NUM = DB_NUM_DEF,
    parameter logic [DB_NUM-1:0]  DB_MAX = DB_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_stable,
    output logic            parity,
    output logic            toggle,
    output logic [N_SW-1:0] changed
);

    // Arming window is DB_MAX+4 cycles; one extra bit keeps it from
    // overflowing when DB_MAX is at the top of its range.
    localparam int              ARM_W    = DB_NUM + 1;
    localparam logic [ARM_W-1:0] ARM_LAST = {1'b0, DB_MAX} + ARM_W'(3);

    logic [N_SW-1:0]  commit;
    logic [N_SW-1:0]  stable_next;

    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             armed_q,   armed_d;
    logic             parity_q,  parity_d;
    logic             toggle_q,  toggle_d;
    logic [N_SW-1:0]  changed_q, changed_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        sw_debounce #(
            .DB_NUM (DB_NUM),
            .DB_MAX (DB_MAX)
        ) u_db (
            .clk       (clk),
            .rst_n     (rst_n),
            .sw_raw    (sw_raw[i]),
            .sw_stable (sw_stable[i]),
            .commit    (commit[i])
        );
    end

    // Levels the channels will hold after this edge; parity is computed
    // from these so it lines up with the updated sw_stable.
    assign stable_next = sw_stable ^ commit;

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            if (arm_cnt_q == ARM_LAST) begin
                armed_d = 1'b1;
            end else begin
                arm_cnt_d = arm_cnt_q + 1'b1;
            end
        end

        parity_d  = ^stable_next;
        // Commits inside the arming window (switches already on at power-up)
        // update the levels but must not fire the lamp.
        toggle_d  = armed_q & (|commit);
        changed_d = armed_q ? commit : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
            parity_q  <= 1'b0;
            toggle_q  <= 1'b0;
            changed_q <= '0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            parity_q  <= parity_d;
            toggle_q  <= toggle_d;
            changed_q <= changed_d;
        end
    end

    assign parity  = parity_q;
    assign toggle  = toggle_q;
    assign changed = changed_q;

endmodule : lamp_switch_conditioner
